// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encoding and parity mode codes.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Mode 2'b11 is reserved and treated exactly like PAR_NONE.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: bit_tick marks the last clk cycle of every serial bit.
module uart_baud_gen #(
    parameter int unsigned clks_per_bit = 16,
    parameter int unsigned div_width    = $clog2(clks_per_bit)
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clear,
    output logic bit_tick
);

    localparam logic [div_width-1:0] LAST = div_width'(clks_per_bit - 1);

    logic [div_width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + div_width'(1);
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: LSB-first serialiser with runtime-selectable parity and
// stop-bit count, configuration latched at the valid/ready handshake.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned word_size    = 8,
    parameter int unsigned clks_per_bit = 16,
    parameter int unsigned div_width    = $clog2(clks_per_bit)
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic [word_size-1:0] data_bus,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    output logic                 serial_out,
    output logic                 busy
);

    localparam int unsigned          CNT_W    = $clog2(word_size + 1);
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(word_size - 1);

    uart_state_e          state_q, state_d;
    logic [word_size-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 par_q, par_d;
    logic                 par_en_q, par_en_d;
    logic                 par_odd_q, par_odd_d;
    logic                 two_stop_q, two_stop_d;
    logic                 serial_q, serial_d;
    logic                 bit_tick;

    // Divider is held at zero while idle, so it starts from zero on entry to START.
    uart_baud_gen #(
        .clks_per_bit (clks_per_bit),
        .div_width    (div_width)
    ) u_baud (
        .clk      (clk),
        .rst_b    (rst_b),
        .clear    (state_q == IDLE),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        par_d      = par_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        two_stop_d = two_stop_q;
        serial_d   = 1'b1;

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    shift_d    = data_bus;
                    par_en_d   = parity_enabled(parity_mode);
                    par_odd_d  = (parity_mode == PAR_ODD);
                    two_stop_d = two_stop;
                    par_d      = 1'b0;
                    bit_cnt_d  = '0;
                    state_d    = START;
                end
            end
            START: begin
                serial_d = 1'b0;
                if (bit_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                serial_d = shift_q[0];
                if (bit_tick) begin
                    par_d   = par_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                serial_d = par_q ^ par_odd_q;
                if (bit_tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                serial_d = 1'b1;
                // The bit counter is reused to count the second stop bit.
                if (bit_tick) begin
                    if (two_stop_q && (bit_cnt_q == '0)) begin
                        bit_cnt_d = CNT_W'(1);
                    end else begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            par_q      <= 1'b0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            serial_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            par_q      <= par_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            two_stop_q <= two_stop_d;
            serial_q   <= serial_d;
        end
    end

    assign serial_out = serial_q;
    assign tx_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_frame.sv
// Randomised self-checking bench for uart_tx_frame (8-bit/16-clk and 9-bit/4-clk instances).
module tb_uart_tx_frame;

    logic       clk;
    logic       rst_b;
    logic       valid_a, valid_b;
    logic [7:0] data_a;
    logic [8:0] data_b;
    logic [1:0] pm_a, pm_b;
    logic       ts_a, ts_b;
    logic       ser_a, ser_b, rdy_a, rdy_b, busy_a, busy_b;

    int n_checks;
    int n_fail;
    int cyc;
    int acc_a[$];
    int acc_b[$];
    int cons[2];

    int         nf;
    logic [8:0] fd[64];
    logic [1:0] fpm[64];
    logic       fts[64];
    logic       fb2b[64];

    uart_tx_frame #(.word_size(8), .clks_per_bit(16)) u_dut_a (
        .clk         (clk),
        .rst_b       (rst_b),
        .data_bus    (data_a),
        .tx_valid    (valid_a),
        .tx_ready    (rdy_a),
        .parity_mode (pm_a),
        .two_stop    (ts_a),
        .serial_out  (ser_a),
        .busy        (busy_a)
    );

    uart_tx_frame #(.word_size(9), .clks_per_bit(4)) u_dut_b (
        .clk         (clk),
        .rst_b       (rst_b),
        .data_bus    (data_b),
        .tx_valid    (valid_b),
        .tx_ready    (rdy_b),
        .parity_mode (pm_b),
        .two_stop    (ts_b),
        .serial_out  (ser_b),
        .busy        (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter plus handshake log: cycle k is the interval after posedge k.
    initial cyc = 0;
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rdy_a && valid_a) acc_a.push_back(cyc);
        if (rdy_b && valid_b) acc_b.push_back(cyc);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic line_of(input bit s);
        return s ? ser_b : ser_a;
    endfunction

    function automatic logic rdy_of(input bit s);
        return s ? rdy_b : rdy_a;
    endfunction

    function automatic logic busy_of(input bit s);
        return s ? busy_b : busy_a;
    endfunction

    task automatic drive(input bit s, input logic v, input logic [8:0] d,
                         input logic [1:0] pm, input logic ts);
        if (s) begin
            valid_b = v; data_b = d; pm_b = pm; ts_b = ts;
        end else begin
            valid_a = v; data_a = d[7:0]; pm_a = pm; ts_a = ts;
        end
    endtask

    task automatic add(input logic [8:0] d, input logic [1:0] pm, input logic ts, input logic b2b);
        fd[nf] = d; fpm[nf] = pm; fts[nf] = ts; fb2b[nf] = b2b;
        nf++;
    endtask

    // Reference frame: start 0, word LSB first, optional parity, stop bits high.
    function automatic bit has_par(input logic [1:0] pm);
        return (pm == 2'b01) || (pm == 2'b10);
    endfunction

    function automatic int nbits(input int w, input logic [1:0] pm, input logic ts);
        return 1 + w + (has_par(pm) ? 1 : 0) + (ts ? 2 : 1);
    endfunction

    function automatic logic exp_bit(input int w, input logic [8:0] d, input logic [1:0] pm, input int j);
        int ones;
        if (j == 0) return 1'b0;
        if (j <= w) return d[j-1];
        if (has_par(pm) && (j == w + 1)) begin
            ones = $countones(int'(d) & ((1 << w) - 1));
            return logic'(ones % 2) ^ (pm == 2'b10);
        end
        return 1'b1;
    endfunction

    task automatic wait_acc(input bit s, output int t, output bit ok);
        int budget = 0;
        ok = 1'b0;
        t  = 0;
        while (((s ? acc_b.size() : acc_a.size()) <= cons[s]) && (budget < 600)) begin
            @(negedge clk);
            budget++;
        end
        if ((s ? acc_b.size() : acc_a.size()) <= cons[s]) begin
            check($sformatf("%s.accept_timeout", s ? "B" : "A"), 0, 1);
        end else begin
            t = s ? acc_b[cons[s]] : acc_a[cons[s]];
            cons[s]++;
            ok = 1'b1;
        end
    endtask

    task automatic run_seq(input bit s, input int n);
        int    w, c, t, exp_t, nb;
        bit    ok, bad, chained;
        logic  e, v, ob;
        string p;
        w = s ? 9 : 8;
        c = s ? 4 : 16;
        p = s ? "B" : "A";
        drive(s, 1'b1, fd[0], fpm[0], fts[0]);
        exp_t = cyc + 1;
        for (int i = 0; i < n; i++) begin
            wait_acc(s, t, ok);
            if (!ok) return;
            check($sformatf("%s%0d.accept_edge", p, i), t, exp_t);
            nb = nbits(w, fpm[i], fts[i]);
            check($sformatf("%s%0d.pre_start_line", p, i), line_of(s), 1);
            check($sformatf("%s%0d.busy_at_accept", p, i), busy_of(s), 1);
            chained = fb2b[i] && (i + 1 < n);
            if (chained) begin
                drive(s, 1'b1, fd[i+1], fpm[i+1], fts[i+1]);
                exp_t = t + nb * c + 1;
            end else begin
                // Inputs change freely mid-frame; the frame in flight must ignore them.
                drive(s, 1'b0, 9'($urandom), 2'($urandom), 1'($urandom));
            end
            for (int b = 0; b < nb; b++) begin
                e   = exp_bit(w, fd[i], fpm[i], b);
                bad = 1'b0;
                ob  = e;
                for (int k = 0; k < c; k++) begin
                    @(negedge clk);
                    v = line_of(s);
                    if ((v !== e) && !bad) begin
                        bad = 1'b1;
                        ob  = v;
                    end
                    if ((b == nb - 1) && (k == c - 2))
                        check($sformatf("%s%0d.ready_low_last", p, i), rdy_of(s), 0);
                end
                check($sformatf("%s%0d.bit%0d", p, i, b), ob, e);
            end
            check($sformatf("%s%0d.ready_end", p, i), rdy_of(s), 1);
            check($sformatf("%s%0d.busy_end", p, i), busy_of(s), 0);
            @(negedge clk);
            check($sformatf("%s%0d.gap_line", p, i), line_of(s), 1);
            if (!chained && (i + 1 < n)) begin
                drive(s, 1'b1, fd[i+1], fpm[i+1], fts[i+1]);
                exp_t = cyc + 1;
            end
        end
        drive(s, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic reset_mid_data();
        int t;
        bit ok;
        drive(0, 1'b1, 9'h000, 2'b00, 1'b0);
        wait_acc(0, t, ok);
        if (!ok) return;
        drive(0, 1'b0, 9'h1FF, 2'b01, 1'b1);
        repeat (56) @(negedge clk);
        check("rst.line_in_data", ser_a, 0);
        check("rst.busy_in_data", busy_a, 1);
        #2;
        rst_b = 1'b0;
        #1;
        check("rst.line_async", ser_a, 1);
        check("rst.ready_async", rdy_a, 1);
        check("rst.busy_async", busy_a, 0);
        @(negedge clk);
        rst_b = 1'b1;
        repeat (20) @(negedge clk);
        check("rst.line_no_trailing", ser_a, 1);
        check("rst.ready_after", rdy_a, 1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cons[0]  = 0;
        cons[1]  = 0;
        rst_b    = 1'b0;
        drive(0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        check("reset.line_a", ser_a, 1);
        check("reset.ready_a", rdy_a, 1);
        check("reset.busy_a", busy_a, 0);
        check("reset.line_b", ser_b, 1);
        check("reset.ready_b", rdy_b, 1);
        check("reset.busy_b", busy_b, 0);
        rst_b = 1'b1;
        @(negedge clk);

        nf = 0;
        add(9'h0A5, 2'b00, 1'b0, 1'b0);
        add(9'h007, 2'b01, 1'b0, 1'b0);
        add(9'h007, 2'b10, 1'b0, 1'b0);
        add(9'h055, 2'b00, 1'b0, 1'b1);
        add(9'h0AA, 2'b00, 1'b0, 1'b0);
        add(9'h0C3, 2'b00, 1'b0, 1'b0);
        add(9'h0C3, 2'b01, 1'b1, 1'b0);
        add(9'h0F0, 2'b11, 1'b0, 1'b0);
        run_seq(0, nf);

        reset_mid_data();

        nf = 0;
        for (int i = 0; i < 12; i++)
            add(9'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        run_seq(0, nf);

        nf = 0;
        add(9'h1FF, 2'b00, 1'b1, 1'b0);
        add(9'h1FF, 2'b01, 1'b1, 1'b1);
        add(9'h100, 2'b10, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++)
            add(9'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        run_seq(1, nf);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
